// File: rtl/jogo_pkg.sv
// ---------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the memory-game control unit and its bench.
//   ESTADO_W         : width of the state register / db_estado
//   INICIAL..FIM_TIMEOUT : state codes (also used to decode db_estado)
//   estado_t         : enumerated state type (includes the two reserved codes)
//   saidas_t         : bundle of every control/result output of the FSM
//   decodifica_saidas: Moore output decode for a given state code
// ---------------------------------------------------------------------------
package jogo_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] INICIAL           = 4'd0;
    localparam logic [ESTADO_W-1:0] PREPARACAO        = 4'd1;
    localparam logic [ESTADO_W-1:0] MOSTRA_ON         = 4'd2;
    localparam logic [ESTADO_W-1:0] MOSTRA_OFF        = 4'd3;
    localparam logic [ESTADO_W-1:0] PROXIMO_LED       = 4'd4;
    localparam logic [ESTADO_W-1:0] INICIA_JOGADA     = 4'd5;
    localparam logic [ESTADO_W-1:0] ESPERA            = 4'd6;
    localparam logic [ESTADO_W-1:0] REGISTRA          = 4'd7;
    localparam logic [ESTADO_W-1:0] COMPARACAO        = 4'd8;
    localparam logic [ESTADO_W-1:0] PROXIMA_JOGADA    = 4'd9;
    localparam logic [ESTADO_W-1:0] PROXIMA_SEQUENCIA = 4'd10;
    localparam logic [ESTADO_W-1:0] FIM_ACERTOU       = 4'd11;
    localparam logic [ESTADO_W-1:0] FIM_ERROU         = 4'd12;
    localparam logic [ESTADO_W-1:0] FIM_TIMEOUT       = 4'd13;

    // Codes 14 and 15 are named so that the enum spans the whole register
    // and a corrupted state can be recovered explicitly.
    typedef enum logic [ESTADO_W-1:0] {
        S_INICIAL           = INICIAL,
        S_PREPARACAO        = PREPARACAO,
        S_MOSTRA_ON         = MOSTRA_ON,
        S_MOSTRA_OFF        = MOSTRA_OFF,
        S_PROXIMO_LED       = PROXIMO_LED,
        S_INICIA_JOGADA     = INICIA_JOGADA,
        S_ESPERA            = ESPERA,
        S_REGISTRA          = REGISTRA,
        S_COMPARACAO        = COMPARACAO,
        S_PROXIMA_JOGADA    = PROXIMA_JOGADA,
        S_PROXIMA_SEQUENCIA = PROXIMA_SEQUENCIA,
        S_FIM_ACERTOU       = FIM_ACERTOU,
        S_FIM_ERROU         = FIM_ERROU,
        S_FIM_TIMEOUT       = FIM_TIMEOUT,
        S_RESERVADO_14      = 4'd14,
        S_RESERVADO_15      = 4'd15
    } estado_t;

    typedef struct packed {
        logic zeraE;
        logic contaE;
        logic zeraS;
        logic contaS;
        logic zeraR;
        logic registraR;
        logic estado_espera;
        logic estado_ledsOn;
        logic estado_ledsOff;
        logic acertou;
        logic errou;
        logic deu_timeout;
        logic pronto;
    } saidas_t;

    // Moore decode: every output starts inactive and only the signals that
    // belong to the given state are raised.
    function automatic saidas_t decodifica_saidas(input estado_t estado);
        saidas_t s;
        s = '0;
        case (estado)
            S_PREPARACAO: begin
                s.zeraE = 1'b1;
                s.zeraS = 1'b1;
                s.zeraR = 1'b1;
            end
            S_MOSTRA_ON:         s.estado_ledsOn  = 1'b1;
            S_MOSTRA_OFF:        s.estado_ledsOff = 1'b1;
            S_PROXIMO_LED:       s.contaE         = 1'b1;
            S_INICIA_JOGADA: begin
                s.zeraE = 1'b1;
                s.zeraR = 1'b1;
            end
            S_ESPERA:            s.estado_espera  = 1'b1;
            S_REGISTRA:          s.registraR      = 1'b1;
            S_PROXIMA_JOGADA:    s.contaE         = 1'b1;
            S_PROXIMA_SEQUENCIA: begin
                s.contaS = 1'b1;
                s.zeraE  = 1'b1;
            end
            S_FIM_ACERTOU: begin
                s.acertou = 1'b1;
                s.pronto  = 1'b1;
            end
            S_FIM_ERROU: begin
                s.errou  = 1'b1;
                s.pronto = 1'b1;
            end
            S_FIM_TIMEOUT: begin
`ifdef TIMEOUT_EN
                s.deu_timeout = 1'b1;
`else
                s.deu_timeout = 1'b0;
`endif
                s.pronto = 1'b1;
            end
            default:             s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_sequencia.sv
// ---------------------------------------------------------------------------
// unidade_controle_sequencia
// Moore FSM sequencing the memory-game datapath (fluxo_dados): shows the
// stored sequence on the LEDs, collects and compares player moves, and
// declares win / lose / timeout.
//
// Configuration macro: TIMEOUT_EN
//   defined   : espera -> fim_timeout on the timeout flag
//   undefined : timeout is ignored, fim_timeout unreachable, deu_timeout = 0
//
// Ports
//   clock                    in  rising-edge clock
//   reset                    in  asynchronous active-low reset (-> inicial)
//   iniciar                  in  start / restart request (level)
//   jogadaIgualMemoria       in  registered move equals ROM word
//   enderecoIgualSequencia   in  address counter equals sequence counter
//   tem_jogada               in  one-cycle pulse, new move present
//   fimS                     in  sequence counter at its last value
//   fimLedsOn / fimLedsOff   in  LED on/off timers expired
//   timeout                  in  move-wait timer expired
//   zeraE contaE zeraS contaS zeraR registraR       out datapath controls
//   estado_espera estado_ledsOn estado_ledsOff      out phase indicators
//   acertou errou deu_timeout pronto                out result flags
//   db_estado                out current state code (ESTADO_W bits)
// ---------------------------------------------------------------------------
module unidade_controle_sequencia
    import jogo_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogadaIgualMemoria,
    input  logic                enderecoIgualSequencia,
    input  logic                tem_jogada,
    input  logic                fimS,
    input  logic                fimLedsOn,
    input  logic                fimLedsOff,
    input  logic                timeout,
    output logic                zeraE,
    output logic                contaE,
    output logic                zeraS,
    output logic                contaS,
    output logic                zeraR,
    output logic                registraR,
    output logic                estado_espera,
    output logic                estado_ledsOn,
    output logic                estado_ledsOff,
    output logic                acertou,
    output logic                errou,
    output logic                deu_timeout,
    output logic                pronto,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;
    saidas_t saidas_s;
    logic    timeout_s;

`ifdef TIMEOUT_EN
    assign timeout_s = timeout;
`else
    // Timeout feature disabled: the flag never influences the FSM.
    assign timeout_s = 1'b0;
    logic  timeout_nao_usado_s;
    assign timeout_nao_usado_s = timeout;
`endif

    // State register with asynchronous return to inicial.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= S_INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            S_INICIAL: begin
                if (iniciar) estado_d = S_PREPARACAO;
                else         estado_d = S_INICIAL;
            end
            S_PREPARACAO:    estado_d = S_MOSTRA_ON;
            S_MOSTRA_ON: begin
                if (fimLedsOn) estado_d = S_MOSTRA_OFF;
                else           estado_d = S_MOSTRA_ON;
            end
            S_MOSTRA_OFF: begin
                // Last shown address reached: hand over to the player.
                if (fimLedsOff) begin
                    if (enderecoIgualSequencia) estado_d = S_INICIA_JOGADA;
                    else                        estado_d = S_PROXIMO_LED;
                end else begin
                    estado_d = S_MOSTRA_OFF;
                end
            end
            S_PROXIMO_LED:   estado_d = S_MOSTRA_ON;
            S_INICIA_JOGADA: estado_d = S_ESPERA;
            S_ESPERA: begin
                // A move arriving together with the timeout still counts.
                if (tem_jogada)     estado_d = S_REGISTRA;
                else if (timeout_s) estado_d = S_FIM_TIMEOUT;
                else                estado_d = S_ESPERA;
            end
            // One extra cycle so the registered move is stable before compare.
            S_REGISTRA:      estado_d = S_COMPARACAO;
            S_COMPARACAO: begin
                if (!jogadaIgualMemoria)                estado_d = S_FIM_ERROU;
                else if (enderecoIgualSequencia && fimS) estado_d = S_FIM_ACERTOU;
                else if (enderecoIgualSequencia)        estado_d = S_PROXIMA_SEQUENCIA;
                else                                    estado_d = S_PROXIMA_JOGADA;
            end
            S_PROXIMA_JOGADA:    estado_d = S_ESPERA;
            // Replay the lengthened sequence from address 0.
            S_PROXIMA_SEQUENCIA: estado_d = S_MOSTRA_ON;
            S_FIM_ACERTOU, S_FIM_ERROU, S_FIM_TIMEOUT: begin
                if (iniciar) estado_d = S_PREPARACAO;
                else         estado_d = estado_q;
            end
            default:         estado_d = S_INICIAL;
        endcase
    end

    // Moore output decode of the current state.
    always_comb begin
        saidas_s = decodifica_saidas(estado_q);
    end

    assign zeraE          = saidas_s.zeraE;
    assign contaE         = saidas_s.contaE;
    assign zeraS          = saidas_s.zeraS;
    assign contaS         = saidas_s.contaS;
    assign zeraR          = saidas_s.zeraR;
    assign registraR      = saidas_s.registraR;
    assign estado_espera  = saidas_s.estado_espera;
    assign estado_ledsOn  = saidas_s.estado_ledsOn;
    assign estado_ledsOff = saidas_s.estado_ledsOff;
    assign acertou        = saidas_s.acertou;
    assign errou          = saidas_s.errou;
    assign deu_timeout    = saidas_s.deu_timeout;
    assign pronto         = saidas_s.pronto;
    assign db_estado      = estado_q;

endmodule

// File: tb/tb_unidade_controle_sequencia.sv
// ---------------------------------------------------------------------------
// tb_unidade_controle_sequencia
// Directed bench for the memory-game control unit. Each step names the state
// the game must be in; a per-cycle checker compares db_estado and the
// expected set of active outputs for that phase of the game.
// ---------------------------------------------------------------------------
module tb_unidade_controle_sequencia;
    import jogo_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic iniciar = 1'b0, jogadaIgualMemoria = 1'b0, enderecoIgualSequencia = 1'b0;
    logic tem_jogada = 1'b0, fimS = 1'b0, fimLedsOn = 1'b0, fimLedsOff = 1'b0;
    logic timeout = 1'b0;
    logic zeraE, contaE, zeraS, contaS, zeraR, registraR;
    logic estado_espera, estado_ledsOn, estado_ledsOff;
    logic acertou, errou, deu_timeout, pronto;
    logic [ESTADO_W-1:0] db_estado;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_state = 4'd0;
    logic chk_en = 1'b0;
    int conta_e_ciclos;

    always #5 clock = ~clock;

    unidade_controle_sequencia dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogadaIgualMemoria(jogadaIgualMemoria),
        .enderecoIgualSequencia(enderecoIgualSequencia),
        .tem_jogada(tem_jogada), .fimS(fimS), .fimLedsOn(fimLedsOn),
        .fimLedsOff(fimLedsOff), .timeout(timeout),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
        .zeraR(zeraR), .registraR(registraR), .estado_espera(estado_espera),
        .estado_ledsOn(estado_ledsOn), .estado_ledsOff(estado_ledsOff),
        .acertou(acertou), .errou(errou), .deu_timeout(deu_timeout),
        .pronto(pronto), .db_estado(db_estado)
    );

    // Output order: zeraE contaE zeraS contaS zeraR registraR espera ledsOn
    //               ledsOff acertou errou deu_timeout pronto
    function automatic logic [12:0] esperado(input logic [3:0] st);
        logic tmo;
`ifdef TIMEOUT_EN
        tmo = 1'b1;
`else
        tmo = 1'b0;
`endif
        case (st)
            4'd1:    return 13'b1_0_1_0_1_0_0_0_0_0_0_0_0;
            4'd2:    return 13'b0_0_0_0_0_0_0_1_0_0_0_0_0;
            4'd3:    return 13'b0_0_0_0_0_0_0_0_1_0_0_0_0;
            4'd4:    return 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
            4'd5:    return 13'b1_0_0_0_1_0_0_0_0_0_0_0_0;
            4'd6:    return 13'b0_0_0_0_0_0_1_0_0_0_0_0_0;
            4'd7:    return 13'b0_0_0_0_0_1_0_0_0_0_0_0_0;
            4'd9:    return 13'b0_1_0_0_0_0_0_0_0_0_0_0_0;
            4'd10:   return 13'b0_0_0_1_0_0_0_0_0_0_0_0_0 | 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
            4'd11:   return 13'b0_0_0_0_0_0_0_0_0_1_0_0_1;
            4'd12:   return 13'b0_0_0_0_0_0_0_0_0_0_1_0_1;
            4'd13:   return {11'b0, tmo, 1'b1};
            default: return 13'b0;
        endcase
    endfunction

    function automatic logic [12:0] atual();
        return {zeraE, contaE, zeraS, contaS, zeraR, registraR, estado_espera,
                estado_ledsOn, estado_ledsOff, acertou, errou, deu_timeout, pronto};
    endfunction

    task automatic check(input string nome, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nome, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the expected game phase.
    always @(negedge clock) begin
        if (chk_en) begin
            check("db_estado", {12'd0, db_estado}, {12'd0, exp_state});
            check("saidas", {3'd0, atual()}, {3'd0, esperado(exp_state)});
            if (contaE === 1'b1) conta_e_ciclos++;
        end
    end

    task automatic tick(input logic [3:0] e);
        @(posedge clock);
        #1;
        exp_state = e;
    endtask

    // From mostra_on with the last address shown: walk into espera.
    task automatic ate_espera();
        fimLedsOn = 1'b1; tick(4'd3); fimLedsOn = 1'b0;
        fimLedsOff = 1'b1; enderecoIgualSequencia = 1'b1; tick(4'd5);
        fimLedsOff = 1'b0; enderecoIgualSequencia = 1'b0; tick(4'd6);
    endtask

    // From espera: one move, ending in comparacao.
    task automatic ate_comparacao();
        tem_jogada = 1'b1; tick(4'd7); tem_jogada = 1'b0; tick(4'd8);
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_estado", {12'd0, db_estado}, 16'd0);
        check("reset_saidas", {3'd0, atual()}, 16'd0);
        @(negedge clock); reset = 1'b1;
        chk_en = 1'b1;
        tick(4'd0); tick(4'd0);

        // Start, then a long LED-on hold
        iniciar = 1'b1; tick(4'd1); iniciar = 1'b0; tick(4'd2);
        for (int i = 0; i < 500; i++) tick(4'd2);
        ate_espera();

        // Correct, non-final move -> proxima_jogada -> espera
        ate_comparacao();
        jogadaIgualMemoria = 1'b1; enderecoIgualSequencia = 1'b0;
        conta_e_ciclos = 0;
        tick(4'd9); jogadaIgualMemoria = 1'b0; tick(4'd6);
        @(posedge clock); #1;
        check("contaE_um_ciclo", 16'(conta_e_ciclos), 16'd1);
        exp_state = 4'd6;

        // Wrong move -> fim_errou, then restart
        ate_comparacao();
        jogadaIgualMemoria = 1'b0; tick(4'd12); tick(4'd12);
        check("errou_literal", {14'd0, errou, pronto}, 16'd3);
        iniciar = 1'b1; tick(4'd1); iniciar = 1'b0; tick(4'd2);

        // More than one LED shown: mostra_off -> proximo_led -> mostra_on
        fimLedsOn = 1'b1; tick(4'd3); fimLedsOn = 1'b0;
        fimLedsOff = 1'b1; tick(4'd4); fimLedsOff = 1'b0; tick(4'd2);
        ate_espera();

        // Last move of last sequence -> fim_acertou
        ate_comparacao();
        jogadaIgualMemoria = 1'b1; enderecoIgualSequencia = 1'b1; fimS = 1'b1;
        tick(4'd11);
        jogadaIgualMemoria = 1'b0; enderecoIgualSequencia = 1'b0; fimS = 1'b0;
        check("acertou_literal", {14'd0, acertou, pronto}, 16'd3);
        // Restart held high across the final state
        iniciar = 1'b1; tick(4'd1); iniciar = 1'b0; tick(4'd2);
        ate_espera();

        // End of a shorter sequence -> proxima_sequencia -> mostra_on
        ate_comparacao();
        jogadaIgualMemoria = 1'b1; enderecoIgualSequencia = 1'b1; fimS = 1'b0;
        tick(4'd10);
        jogadaIgualMemoria = 1'b0; enderecoIgualSequencia = 1'b0;
        check("prox_seq_literal", {14'd0, contaS, zeraE}, 16'd3);
        tick(4'd2);
        ate_espera();

        // Timeout in espera
        timeout = 1'b1;
`ifdef TIMEOUT_EN
        tick(4'd13); timeout = 1'b0;
        check("deu_timeout_literal", {15'd0, deu_timeout}, 16'd1);
        iniciar = 1'b1; tick(4'd1); iniciar = 1'b0; tick(4'd2);
        ate_espera();
`else
        tick(4'd6); tick(4'd6); timeout = 1'b0;
        check("timeout_ignorado", {15'd0, deu_timeout}, 16'd0);
`endif
        // Move and timeout together: the move wins
        timeout = 1'b1; tem_jogada = 1'b1; tick(4'd7);
        timeout = 1'b0; tem_jogada = 1'b0; tick(4'd8);
        jogadaIgualMemoria = 1'b1; tick(4'd9); jogadaIgualMemoria = 1'b0; tick(4'd6);

        // Asynchronous reset mid-cycle while in espera
        @(posedge clock); #3;
        reset = 1'b0; #1;
        exp_state = 4'd0;
        check("reset_assinc_estado", {12'd0, db_estado}, 16'd0);
        check("reset_assinc_saidas", {3'd0, atual()}, 16'd0);
        tick(4'd0); tick(4'd0);
        #3; reset = 1'b1;
        tick(4'd0); tick(4'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout_global: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

endmodule
